frame_stream_tx: RTL and testbench

- Transmit end of the frame stream consumed by the frame filter's rotating FIFO.
- Buffers payload beats from an upstream producer and emits framed AXI-stream: a header run flagged TUSER=2'b11, then payload flagged 2'b00, with the last payload beat flagged 2'b10.
- Sits directly upstream of rot_fifo; its m_* ports connect to rot_fifo's s_*/in_d0/TUSER.

---
 rtl/frame_pkg.sv | 14 +
 rtl/tx_sync_fifo.sv | 44 ++++
 rtl/frame_stream_tx.sv | 132 +++++++++++++
 tb/tb_frame_stream_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared TUSER frame-flag encodings and the transmit FSM state type.
package frame_pkg;

   localparam logic [1:0] TUSER_HDR  = 2'b11;
   localparam logic [1:0] TUSER_PAY  = 2'b00;
   localparam logic [1:0] TUSER_LAST = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

endpackage

// File: rtl/tx_sync_fifo.sv
// Single-clock payload FIFO with full/empty flags; a full FIFO refuses writes
// even when a read happens in the same cycle.
module tx_sync_fifo #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              do_wr, do_rd;

   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   // Extra pointer bit tells full from empty when the index bits match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/frame_stream_tx.sv
// Framed AXI-stream transmitter: header run, then buffered payload beats.
// Define FRAME_CNT_EN to add the frame_count output.
module frame_stream_tx
   import frame_pkg::*;
#(
   parameter int DATA_W     = 4,
   parameter int HDR_LEN    = 14,
   parameter int PAY_LEN    = 64,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              s_tvalid,
   input  logic [DATA_W-1:0] s_tdata,
   output logic              s_tready,
   output logic              m_tvalid,
   output logic [DATA_W-1:0] m_tdata,
   output logic [1:0]        m_tuser,
   input  logic              m_tready
`ifdef FRAME_CNT_EN
   ,
   output logic [15:0]       frame_count
`endif
);

   state_t            state;
   logic [7:0]        hdr_cnt;
   logic [15:0]       pay_cnt;
   logic              fifo_full, fifo_empty, pop;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              hdr_done, pay_last;
   logic [1:0]        next_pay_user;

   assign s_tready      = !fifo_full && !reset;
   assign hdr_done      = (hdr_cnt == 8'(HDR_LEN));
   assign pay_last      = (pay_cnt == 16'(PAY_LEN));
   assign next_pay_user = ((pay_cnt + 16'd1) == 16'(PAY_LEN)) ? TUSER_LAST : TUSER_PAY;

   tx_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (s_tvalid && s_tready),
      .wr_data (s_tdata),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Pop when the output register is free (or being handed off) and the
   // next beat due is a payload beat of the current frame.
   always_comb begin
      pop = 1'b0;
      if (m_tready && !fifo_empty) begin
         case (state)
            HEADER:  pop = m_tvalid && hdr_done;
            PAYLOAD: pop = !(m_tvalid && pay_last);
            default: pop = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tuser  <= TUSER_PAY;
         hdr_cnt  <= '0;
         pay_cnt  <= '0;
`ifdef FRAME_CNT_EN
         frame_count <= '0;
`endif
      end else if (m_tready) begin
         if (pop) begin
            state    <= PAYLOAD;
            m_tvalid <= 1'b1;
            m_tdata  <= fifo_rd_data;
            m_tuser  <= next_pay_user;
            pay_cnt  <= pay_cnt + 16'd1;
         end else begin
            case (state)
               IDLE: begin
                  if (enable) begin
                     state    <= HEADER;
                     m_tvalid <= 1'b1;
                     m_tdata  <= DATA_W'(8'd1);
                     m_tuser  <= TUSER_HDR;
                     hdr_cnt  <= 8'd1;
                     pay_cnt  <= '0;
                  end
               end
               HEADER: begin
                  if (m_tvalid && !hdr_done) begin
                     m_tdata <= DATA_W'(hdr_cnt + 8'd1);
                     hdr_cnt <= hdr_cnt + 8'd1;
                  end else if (m_tvalid) begin
                     // Header finished but no payload buffered yet.
                     state    <= PAYLOAD;
                     m_tvalid <= 1'b0;
                  end
               end
               PAYLOAD: begin
                  if (m_tvalid && pay_last) begin
`ifdef FRAME_CNT_EN
                     frame_count <= frame_count + 16'd1;
`endif
                     if (enable) begin
                        state    <= HEADER;
                        m_tdata  <= DATA_W'(8'd1);
                        m_tuser  <= TUSER_HDR;
                        hdr_cnt  <= 8'd1;
                        pay_cnt  <= '0;
                     end else begin
                        state    <= IDLE;
                        m_tvalid <= 1'b0;
                     end
                  end else if (m_tvalid) begin
                     m_tvalid <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_stream_tx.sv
// Scoreboard bench: producer pushes accepted beats, monitor checks every
// output handshake against header position / payload order.
module tb_frame_stream_tx;

   localparam int DATA_W = 4, HDR_LEN = 14, PAY_LEN = 64, FIFO_DEPTH = 16;
   localparam int FRAME = HDR_LEN + PAY_LEN;

   logic              tb_clk = 1'b0;
   logic              reset, enable, s_tvalid, s_tready, m_tvalid, m_tready;
   logic [DATA_W-1:0] s_tdata, m_tdata;
   logic [1:0]        m_tuser;
`ifdef FRAME_CNT_EN
   logic [15:0]       frame_count;
   logic [15:0]       fc = '0;
`endif

   always #5 tb_clk = ~tb_clk;

   frame_stream_tx #(
      .DATA_W (DATA_W), .HDR_LEN (HDR_LEN), .PAY_LEN (PAY_LEN), .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clock (tb_clk), .reset (reset), .enable (enable),
      .s_tvalid (s_tvalid), .s_tdata (s_tdata), .s_tready (s_tready),
      .m_tvalid (m_tvalid), .m_tdata (m_tdata), .m_tuser (m_tuser), .m_tready (m_tready)
`ifdef FRAME_CNT_EN
      , .frame_count (frame_count)
`endif
   );

   int                checks = 0, errors = 0;
   logic [DATA_W-1:0] pq [$];
   int                pos = 0, frames_done = 0, prod_count = 0, prod_limit = 0;
   logic [DATA_W-1:0] prod_val = 4'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Producer: 1..14 repeating, up to prod_limit accepted beats in total.
   initial begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      forever begin
         @(negedge tb_clk);
         if (s_tvalid && s_tready) begin
            pq.push_back(s_tdata);
            prod_count++;
            prod_val = (prod_val == 4'd14) ? 4'd1 : prod_val + 4'd1;
         end
         @(posedge tb_clk);
         #1;
         s_tdata  = prod_val;
         s_tvalid = (prod_count < prod_limit);
      end
   end

   // Monitor: checks each handshake and hold-stability under backpressure.
   initial begin
      logic              prev_hold;
      logic [5:0]        prev_beat;
      logic [DATA_W-1:0] exp_d;
      logic [1:0]        exp_u;
      prev_hold = 1'b0;
      prev_beat = '0;
      forever begin
         @(negedge tb_clk);
         if (reset) begin
            pq.delete();
            pos = 0;
            prev_hold = 1'b0;
`ifdef FRAME_CNT_EN
            fc = '0;
`endif
         end else begin
            if (prev_hold) begin
               chk("hold_valid", 32'(m_tvalid), 32'd1);
               chk("hold_beat", 32'({m_tuser, m_tdata}), 32'(prev_beat));
            end
            if (m_tvalid && m_tready) begin
               if (pos < HDR_LEN) begin
                  exp_d = DATA_W'(pos + 1);
                  exp_u = 2'b11;
                  chk("hdr_beat", 32'({m_tuser, m_tdata}), 32'({exp_u, exp_d}));
               end else if (pq.size() == 0) begin
                  timeout("pay_underflow");
               end else begin
                  exp_d = pq.pop_front();
                  exp_u = (pos == FRAME - 1) ? 2'b10 : 2'b00;
                  chk("pay_beat", 32'({m_tuser, m_tdata}), 32'({exp_u, exp_d}));
               end
`ifdef FRAME_CNT_EN
               if (pos == FRAME - 1) begin
                  chk("frame_count", 32'(frame_count), 32'(fc));
                  fc = fc + 16'd1;
               end
`endif
               pos++;
               if (pos == FRAME) begin
                  pos = 0;
                  frames_done++;
               end
            end
            prev_hold = m_tvalid && !m_tready;
            prev_beat = {m_tuser, m_tdata};
         end
      end
   end

   task automatic wait_valid(input string name);
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge tb_clk);
         found = m_tvalid;
      end
      if (!found) timeout(name);
   endtask

   task automatic wait_frames(input int n, input int bound, input string name);
      bit found = 0;
      for (int i = 0; i < bound && !found; i++) begin
         @(posedge tb_clk);
         found = (frames_done >= n);
      end
      if (!found) timeout(name);
   endtask

   task automatic wait_pos(input int p, input string name);
      bit found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge tb_clk);
         found = (pos == p);
      end
      if (!found) timeout(name);
   endtask

   initial begin
      int f0, gaps;
      bit found;
      reset = 1'b1; enable = 1'b0; m_tready = 1'b0;
      repeat (3) @(posedge tb_clk);
      @(negedge tb_clk);
      chk("rst_mvalid", 32'(m_tvalid), 32'd0);
      chk("rst_mdata", 32'(m_tdata), 32'd0);
      chk("rst_muser", 32'(m_tuser), 32'd0);
      chk("rst_sready", 32'(s_tready), 32'd0);
      @(posedge tb_clk); #1 reset = 1'b0;

      // Fill FIFO with downstream stalled: 16 accepted, 17th held.
      prod_limit = 17;
      repeat (25) @(posedge tb_clk);
      @(negedge tb_clk);
      chk("fill_count", 32'(prod_count), 32'd16);
      chk("full_sready", 32'(s_tready), 32'd0);
      chk("held_svalid", 32'(s_tvalid), 32'd1);
      chk("stall_mvalid", 32'(m_tvalid), 32'd0);
      @(posedge tb_clk); #1;
      f0 = frames_done; m_tready = 1'b1; enable = 1'b1; prod_limit = 64;
      wait_valid("start1");
      enable = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge tb_clk);
         found = (prod_count >= 17);
      end
      if (!found) timeout("slot_freed");
      wait_frames(f0 + 1, 300, "frame1");
      @(negedge tb_clk);
      chk("idle_after1", 32'(m_tvalid), 32'd0);

      // Three back-to-back frames, no gaps.
      @(posedge tb_clk); #1;
      f0 = frames_done; prod_limit += 3 * PAY_LEN; enable = 1'b1;
      wait_valid("start_b2b");
      gaps = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (!m_tvalid) gaps++;
         if (i == 2 * FRAME + 14) enable = 1'b0;
         @(negedge tb_clk);
      end
      chk("b2b_gaps", 32'(gaps), 32'd0);
      chk("b2b_idle", 32'(m_tvalid), 32'd0);
      chk("b2b_frames", 32'(frames_done), 32'(f0 + 3));

      // Random backpressure for one frame.
      @(posedge tb_clk); #1;
      f0 = frames_done; prod_limit += PAY_LEN; enable = 1'b1;
      wait_valid("start_rnd");
      enable = 1'b0;
      found = 0;
      for (int i = 0; i < 800 && !found; i++) begin
         @(posedge tb_clk); #1;
         m_tready = 1'($urandom_range(0, 1));
         found = (frames_done >= f0 + 1);
      end
      if (!found) timeout("frame_rnd");
      m_tready = 1'b1;
      wait_frames(f0 + 1, 20, "frame_rnd_end");

      // Producer stalls after payload beat 20.
      @(posedge tb_clk); #1;
      f0 = frames_done; prod_limit += 20; enable = 1'b1;
      wait_valid("start_bub");
      enable = 1'b0;
      wait_pos(HDR_LEN + 20, "pay20");
      for (int i = 0; i < 10; i++) begin
         @(negedge tb_clk);
         chk("bubble", 32'(m_tvalid), 32'd0);
      end
      prod_limit += PAY_LEN - 20;
      wait_frames(f0 + 1, 200, "frame_bub");

      // Reset at payload beat 30, then a fresh frame.
      @(posedge tb_clk); #1;
      f0 = frames_done; prod_limit += PAY_LEN; enable = 1'b1;
      wait_valid("start_rst");
      enable = 1'b0;
      wait_pos(HDR_LEN + 29, "pay30");
      #1 reset = 1'b1;
      @(negedge tb_clk);
      chk("midrst_sready", 32'(s_tready), 32'd0);
      @(posedge tb_clk); #1 reset = 1'b0;
      @(negedge tb_clk);
      chk("midrst_mvalid", 32'(m_tvalid), 32'd0);
`ifdef FRAME_CNT_EN
      chk("midrst_fcount", 32'(frame_count), 32'd0);
`endif
      prod_limit = prod_count + PAY_LEN;
      enable = 1'b1;
      wait_valid("start_post");
      chk("restart_hdr", 32'({m_tuser, m_tdata}), 32'h31);
      enable = 1'b0;
      wait_frames(f0 + 1, 300, "frame_post");
      repeat (3) @(negedge tb_clk);
      chk("final_idle", 32'(m_tvalid), 32'd0);
      chk("pq_empty", 32'(pq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
